// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD card model: command indices, tokens,
// R1 flag masks, OCR values and the responder state encoding.
package sd_spi_pkg;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
  localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
  localparam logic [5:0] CMD_WRITE_SINGLE    = 6'd24;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD         = 6'd55;
  localparam logic [5:0] CMD_READ_OCR        = 6'd58;

  localparam logic [7:0] TOKEN_START  = 8'hFE;
  localparam logic [7:0] DATA_RESP_OK = 8'h05;
  localparam logic [7:0] BYTE_IDLE    = 8'hFF;

  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_CRC_ERR   = 8'h08;
  localparam logic [7:0] R1_PARAM_ERR = 8'h40;

  localparam logic [7:0] CRC_CMD0 = 8'h95;
  localparam logic [7:0] CRC_CMD8 = 8'h87;

  localparam logic [31:0] OCR_BASE = 32'h80FF8000;
  localparam logic [31:0] OCR_CCS  = 32'h40000000;

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD_RX, ST_RESP_GAP, ST_RESP_TX, ST_RD_GAP, ST_RD_DATA,
    ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_WR_BUSY
  } card_state_t;

endpackage

// File: rtl/sd_spi_byte_if.sv
// SPI mode-0 bit engine: synchronises cs/sclk/mosi, detects sclk edges,
// shifts mosi in on rises and shifts a loaded byte out on miso on falls.
module sd_spi_byte_if
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  input  logic       rx_sync,
  output logic       sel,
  output logic       bit_valid,
  output logic       rx_bit,
  output logic       byte_valid,
  output logic [7:0] rx_sr,
  output logic       tx_empty,
  output logic       miso
);

  logic [1:0] cs_ff, sclk_ff, mosi_ff;
  logic       sclk_d;
  logic [2:0] rx_cnt;
  logic [7:0] tx_sr;
  logic [3:0] tx_cnt;
  logic       rise, fall;

  assign sel      = ~cs_ff[1];
  assign rise     = sel & sclk_ff[1] & ~sclk_d;
  assign fall     = sel & ~sclk_ff[1] & sclk_d;
  assign tx_empty = (tx_cnt == '0);
  assign rx_bit   = rx_sr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_ff      <= '1;
      sclk_ff    <= '0;
      mosi_ff    <= '1;
      sclk_d     <= 1'b0;
      rx_sr      <= BYTE_IDLE;
      rx_cnt     <= '0;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      tx_sr      <= BYTE_IDLE;
      tx_cnt     <= '0;
      miso       <= 1'b1;
    end else begin
      cs_ff      <= {cs_ff[0], cs};
      sclk_ff    <= {sclk_ff[0], sclk};
      mosi_ff    <= {mosi_ff[0], mosi};
      sclk_d     <= sclk_ff[1];
      bit_valid  <= rise;
      byte_valid <= rise && (rx_cnt == 3'd7);
      if (!sel) begin
        rx_sr  <= BYTE_IDLE;
        rx_cnt <= '0;
        tx_cnt <= '0;
        miso   <= 1'b1;
      end else begin
        if (rise) begin
          rx_sr  <= {rx_sr[6:0], mosi_ff[1]};
          rx_cnt <= rx_cnt + 3'd1;
        end else if (rx_sync) begin
          rx_cnt <= '0;
        end
        // A load landing on the same cycle as a fall drives its MSB immediately
        // so the byte keeps its slot.
        if (fall) begin
          if (tx_load) begin
            miso   <= tx_data[7];
            tx_sr  <= {tx_data[6:0], 1'b1};
            tx_cnt <= 4'd7;
          end else if (!tx_empty) begin
            miso   <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b1};
            tx_cnt <= tx_cnt - 4'd1;
          end else begin
            miso <= 1'b1;
          end
        end else if (tx_load) begin
          tx_sr  <= tx_data;
          tx_cnt <= 4'd8;
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes host commands, answers R1/R3/R7 and serves
// single-block reads/writes from an external byte-wide memory.
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned MEM_AW       = 16,
  parameter int unsigned ACMD41_POLLS = 2,
  parameter int unsigned NCR          = 1,
  parameter int unsigned NAC          = 2,
  parameter int unsigned BUSY_BYTES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        card_state
);

  localparam int unsigned BLK_AW = MEM_AW - 9;

  card_state_t       state, resp_next;
  logic [44:0]       frame_sr;
  logic [5:0]        bit_cnt;
  logic [9:0]        cnt;
  logic [39:0]       resp_buf;
  logic [2:0]        resp_len;
  logic              initialised, app_flag, rd_pend;
  logic [7:0]        poll_cnt, rd_buf;
  logic [BLK_AW-1:0] blk;

  logic       sel, bit_valid, rx_bit, byte_valid, tx_empty, tx_load, rx_sync;
  logic [7:0] rx_sr, tx_data;

  logic [5:0]  f_cmd;
  logic [31:0] f_arg, dec_tail;
  logic [7:0]  f_crc, dec_r1, idle_bit;
  logic        dec_long, blk_oor, poll_done;
  card_state_t dec_next;

  sd_spi_byte_if u_byte_if (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
    .tx_load(tx_load), .tx_data(tx_data), .rx_sync(rx_sync),
    .sel(sel), .bit_valid(bit_valid), .rx_bit(rx_bit), .byte_valid(byte_valid),
    .rx_sr(rx_sr), .tx_empty(tx_empty), .miso(miso)
  );

  assign card_state = state;
  // Fields are taken while the 48th bit is on rx_bit.
  assign f_cmd     = frame_sr[44:39];
  assign f_arg     = frame_sr[38:7];
  assign f_crc     = {frame_sr[6:0], rx_bit};
  assign idle_bit  = {7'b0, ~initialised};
  assign blk_oor   = (f_arg >> BLK_AW) != 32'd0;
  assign poll_done = 32'(poll_cnt) >= ACMD41_POLLS;

  always_comb begin
    dec_r1   = idle_bit;
    dec_tail = '0;
    dec_long = 1'b0;
    dec_next = ST_HUNT;
    case (f_cmd)
      CMD_GO_IDLE: dec_r1 = R1_IDLE | ((f_crc != CRC_CMD0) ? R1_CRC_ERR : 8'h00);
      CMD_SEND_IF_COND:
        if (f_crc != CRC_CMD8) dec_r1 = idle_bit | R1_CRC_ERR;
        else begin
          dec_long = 1'b1;
          dec_tail = {24'h000001, f_arg[7:0]};
        end
      CMD_READ_OCR: begin
        dec_long = 1'b1;
        dec_tail = initialised ? (OCR_BASE | OCR_CCS) : OCR_BASE;
      end
      CMD_APP_CMD: dec_r1 = idle_bit;
      CMD_SD_SEND_OP_COND:
        if (!app_flag)      dec_r1 = idle_bit | R1_ILLEGAL;
        else if (poll_done) dec_r1 = 8'h00;
        else                dec_r1 = R1_IDLE;
      CMD_READ_SINGLE, CMD_WRITE_SINGLE:
        if (!initialised) dec_r1 = R1_ILLEGAL | R1_IDLE;
        else if (blk_oor) dec_r1 = R1_PARAM_ERR;
        else dec_next = (f_cmd == CMD_READ_SINGLE) ? ST_RD_GAP : ST_WR_TOKEN;
      default: dec_r1 = idle_bit | R1_ILLEGAL;
    endcase
  end

  always_comb begin
    tx_load = 1'b0;
    tx_data = BYTE_IDLE;
    if (sel && tx_empty) begin
      case (state)
        ST_RESP_GAP: tx_load = 1'b1;
        ST_RESP_TX: begin
          tx_load = 1'b1;
          tx_data = resp_buf[39:32];
        end
        ST_RD_GAP: begin
          tx_load = 1'b1;
          if (cnt == 10'(NAC)) tx_data = TOKEN_START;
        end
        ST_RD_DATA: begin
          tx_load = 1'b1;
          if (cnt < 10'd512) tx_data = rd_buf;
        end
        ST_WR_RESP: begin
          tx_load = 1'b1;
          tx_data = DATA_RESP_OK;
        end
        ST_WR_BUSY: begin
          tx_load = 1'b1;
          tx_data = 8'h00;
        end
        default: ;
      endcase
    end
    rx_sync = sel && (state == ST_WR_TOKEN) && bit_valid && (rx_sr == TOKEN_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HUNT;
      resp_next   <= ST_HUNT;
      frame_sr    <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      resp_buf    <= '1;
      resp_len    <= 3'd1;
      initialised <= 1'b0;
      app_flag    <= 1'b0;
      poll_cnt    <= '0;
      blk         <= '0;
      rd_pend     <= 1'b0;
      rd_buf      <= '0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      rd_pend <= mem_rd;
      if (rd_pend) rd_buf <= mem_rdata;
      if (!sel) begin
        state    <= ST_HUNT;
        app_flag <= 1'b0;
        bit_cnt  <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          ST_HUNT:
            if (bit_valid && !rx_bit) begin
              frame_sr <= '0;
              bit_cnt  <= 6'd1;
              state    <= ST_CMD_RX;
            end
          ST_CMD_RX:
            if (bit_valid) begin
              frame_sr <= {frame_sr[43:0], rx_bit};
              bit_cnt  <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd1 && !rx_bit) begin
                state <= ST_HUNT;
              end else if (bit_cnt == 6'd47) begin
                resp_buf  <= {dec_r1, dec_tail};
                resp_len  <= dec_long ? 3'd5 : 3'd1;
                resp_next <= dec_next;
                blk       <= f_arg[BLK_AW-1:0];
                app_flag  <= (f_cmd == CMD_APP_CMD);
                if (f_cmd == CMD_GO_IDLE) begin
                  initialised <= 1'b0;
                  poll_cnt    <= '0;
                end
                if (f_cmd == CMD_SD_SEND_OP_COND && app_flag) begin
                  if (poll_done) initialised <= 1'b1;
                  else           poll_cnt    <= poll_cnt + 8'd1;
                end
                cnt   <= '0;
                state <= ST_RESP_GAP;
              end
            end
          ST_RESP_GAP:
            if (tx_load) begin
              if (cnt == 10'(NCR - 1)) begin
                cnt   <= '0;
                state <= ST_RESP_TX;
              end else cnt <= cnt + 10'd1;
            end
          ST_RESP_TX:
            if (tx_load) begin
              resp_buf <= {resp_buf[31:0], BYTE_IDLE};
              if (cnt == {7'b0, resp_len} - 10'd1) begin
                cnt   <= '0;
                state <= resp_next;
              end else cnt <= cnt + 10'd1;
            end
          ST_RD_GAP:
            if (tx_load) begin
              if (cnt == 10'(NAC)) begin
                mem_rd   <= 1'b1;
                mem_addr <= {blk, 9'd0};
                cnt      <= '0;
                state    <= ST_RD_DATA;
              end else cnt <= cnt + 10'd1;
            end
          ST_RD_DATA:
            // Each byte load prefetches the next one into rd_buf.
            if (tx_load) begin
              cnt <= cnt + 10'd1;
              if (cnt < 10'd511) begin
                mem_rd   <= 1'b1;
                mem_addr <= {blk, cnt[8:0] + 9'd1};
              end
              if (cnt == 10'd513) begin
                cnt   <= '0;
                state <= ST_HUNT;
              end
            end
          ST_WR_TOKEN:
            if (rx_sync) begin
              cnt   <= '0;
              state <= ST_WR_DATA;
            end
          ST_WR_DATA:
            if (byte_valid) begin
              mem_wr    <= 1'b1;
              mem_addr  <= {blk, cnt[8:0]};
              mem_wdata <= rx_sr;
              if (cnt == 10'd511) begin
                cnt   <= '0;
                state <= ST_WR_CRC;
              end else cnt <= cnt + 10'd1;
            end
          ST_WR_CRC:
            if (byte_valid) begin
              if (cnt == 10'd1) begin
                cnt   <= '0;
                state <= ST_WR_RESP;
              end else cnt <= cnt + 10'd1;
            end
          ST_WR_RESP:
            if (tx_load) begin
              cnt   <= '0;
              state <= (BUSY_BYTES == 0) ? ST_HUNT : ST_WR_BUSY;
            end
          ST_WR_BUSY:
            if (tx_load) begin
              if (cnt == 10'(BUSY_BYTES - 1)) begin
                cnt   <= '0;
                state <= ST_HUNT;
              end else cnt <= cnt + 10'd1;
            end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed host-side bench for the SD SPI card model with a byte-wide memory.
module tb_sd_spi_card_responder;

  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        miso, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;
  logic [3:0]  card_state;

  logic [7:0]  mem [0:65535];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;

  sd_spi_card_responder #(
    .MEM_AW(16), .ACMD41_POLLS(2), .NCR(1), .NAC(2), .BUSY_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .card_state(card_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count++;
    end
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bitx(input logic b, output logic r);
    mosi = b;
    #(HALF);
    r = miso;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic read_word(input int n, output logic [31:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, b);
      v = {v[23:0], b};
    end
  endtask

  task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] crc,
                          output logic [7:0] r1, output int nff);
    logic [47:0] f;
    logic [7:0]  b;
    f = {2'b01, cmd, arg, crc};
    for (int k = 5; k >= 0; k--) xfer(f[k*8 +: 8], b);
    nff = 0;
    r1 = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      xfer(8'hFF, b);
      if (b != 8'hFF) begin
        r1 = b;
        break;
      end
      nff++;
    end
  endtask

  logic [7:0]  r1, b;
  logic [31:0] w;
  logic        r;
  int          nff, bad, wr0, rd0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = (i >= 'h600 && i < 'h800) ? 8'(i) : 8'h00;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("reset_miso", miso, 1);
    chk("reset_mem_rd", mem_rd, 0);
    chk("reset_mem_wr", mem_wr, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_state", card_state, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    #(HALF);

    send_cmd(6'd17, 32'd3, 8'h01, r1, nff);
    chk("cmd17_uninit_r1", r1, 8'h05);
    xfer(8'hFF, b);

    send_cmd(6'd0, 32'd0, 8'h95, r1, nff);
    chk("cmd0_r1", r1, 8'h01);
    chk("cmd0_ncr", nff, 1);
    xfer(8'hFF, b);

    send_cmd(6'd8, 32'h000001AA, 8'h87, r1, nff);
    chk("cmd8_r1", r1, 8'h01);
    read_word(4, w);
    chk("cmd8_r7_tail", w, 32'h000001AA);
    xfer(8'hFF, b);

    send_cmd(6'd8, 32'h000001AA, 8'h00, r1, nff);
    chk("cmd8_badcrc_r1", r1, 8'h09);
    xfer(8'hFF, b);

    send_cmd(6'd41, 32'h40000000, 8'h01, r1, nff);
    chk("cmd41_noapp_r1", r1, 8'h05);
    xfer(8'hFF, b);

    send_cmd(6'd55, 32'd0, 8'h01, r1, nff);
    chk("cmd55_a_r1", r1, 8'h01);
    send_cmd(6'd41, 32'h40000000, 8'h01, r1, nff);
    chk("acmd41_1_r1", r1, 8'h01);
    send_cmd(6'd55, 32'd0, 8'h01, r1, nff);
    chk("cmd55_b_r1", r1, 8'h01);
    send_cmd(6'd41, 32'h40000000, 8'h01, r1, nff);
    chk("acmd41_2_r1", r1, 8'h01);
    send_cmd(6'd55, 32'd0, 8'h01, r1, nff);
    chk("cmd55_c_r1", r1, 8'h01);
    send_cmd(6'd41, 32'h40000000, 8'h01, r1, nff);
    chk("acmd41_3_r1", r1, 8'h00);
    xfer(8'hFF, b);

    send_cmd(6'd58, 32'd0, 8'h01, r1, nff);
    chk("cmd58_r1", r1, 8'h00);
    read_word(4, w);
    chk("cmd58_ocr", w, 32'hC0FF8000);
    xfer(8'hFF, b);

    send_cmd(6'd2, 32'd0, 8'h01, r1, nff);
    chk("unknown_r1", r1, 8'h04);
    xfer(8'hFF, b);

    send_cmd(6'd17, 32'd128, 8'h01, r1, nff);
    chk("cmd17_oor_r1", r1, 8'h40);
    xfer(8'hFF, b);

    rd0 = rd_count;
    send_cmd(6'd17, 32'd3, 8'h01, r1, nff);
    chk("cmd17_r1", r1, 8'h00);
    read_word(3, w);
    chk("cmd17_nac_token", w, 32'h00FFFFFE);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, b);
      if (b !== 8'(i)) bad++;
    end
    chk("cmd17_data_bad", bad, 0);
    read_word(3, w);
    chk("cmd17_crc_idle", w, 32'h00FFFFFF);
    chk("cmd17_mem_rd_count", rd_count - rd0, 512);
    chk("cmd17_end_state", card_state, 0);

    wr0 = wr_count;
    send_cmd(6'd24, 32'd5, 8'h01, r1, nff);
    chk("cmd24_r1", r1, 8'h00);
    xfer(8'hFF, b);
    for (int i = 0; i < 3; i++) bitx(1'b1, r);
    xfer(8'hFE, b);
    for (int i = 0; i < 512; i++) xfer(8'hA5, b);
    xfer(8'h12, b);
    xfer(8'h34, b);
    xfer(8'hFF, b);
    chk("cmd24_data_resp", b, 8'h05);
    read_word(4, w);
    chk("cmd24_busy", w, 32'h00000000);
    xfer(8'hFF, b);
    chk("cmd24_after_busy", b, 8'hFF);
    chk("cmd24_mem_wr_count", wr_count - wr0, 512);
    bad = 0;
    for (int i = 'hA00; i < 'hC00; i++) if (mem[i] !== 8'hA5) bad++;
    chk("cmd24_mem_bad", bad, 0);
    chk("cmd24_mem_below", mem['h9FF], 8'h00);
    chk("cmd24_mem_above", mem['hC00], 8'h00);

    wr0 = wr_count;
    send_cmd(6'd24, 32'd6, 8'h01, r1, nff);
    chk("abort_r1", r1, 8'h00);
    xfer(8'hFF, b);
    xfer(8'hFE, b);
    for (int i = 0; i < 100; i++) xfer(8'h3C, b);
    cs = 1'b1;
    #30;
    chk("abort_state", card_state, 0);
    chk("abort_miso", miso, 1);
    for (int i = 0; i < 16; i++) bitx(i[0], r);
    chk("abort_wr_count", wr_count - wr0, 100);
    chk("abort_mem_last", mem['hC00 + 99], 8'h3C);
    chk("abort_mem_next", mem['hC00 + 100], 8'h00);
    cs = 1'b0;
    #(HALF);

    send_cmd(6'd58, 32'd0, 8'h01, r1, nff);
    chk("post_abort_r1", r1, 8'h00);
    read_word(4, w);
    chk("post_abort_ocr", w, 32'hC0FF8000);
    xfer(8'hFF, b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
